// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID, ID/EX and EX/MEM pipeline registers.
// Handles load-use hazards, MEM-stage taken-branch flushes and IO-access freezes with timeout.
module pipe_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int IO_TIMEOUT        = 255,
  parameter int TW                = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  input  logic       mem_branch_taken,
  input  logic       mem_io_access,
  input  logic       io_ack,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       idex_stall,
  output logic       idex_bubble,
  output logic       exmem_stall,
  output logic       flush,
  output logic       io_req,
  output logic       io_timeout,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    BR_FLUSH   = 2'd2,
    IO_WAIT    = 2'd3
  } state_t;

  localparam logic [TW-1:0] ONE        = TW'(1);
  localparam logic [TW-1:0] CNT_MAX    = {TW{1'b1}};
  localparam logic [TW-1:0] FLUSH_LOAD = TW'(FLUSH_CYCLES - 1);
  localparam logic [TW-1:0] STALL_LOAD = TW'(LOAD_STALL_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LIMIT  = TW'(IO_TIMEOUT);

  state_t        cur, nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  logic          tmo_q, tmo_nxt;

  logic pc_stall_c, ifid_stall_c, idex_stall_c, idex_bubble_c;
  logic exmem_stall_c, flush_c, io_req_c;

  function automatic logic load_use(input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic use2, input logic [4:0] rd,
                                    input logic memread);
    return memread && (rd != 5'd0) && ((rd == rs1) || (use2 && (rd == rs2)));
  endfunction

  function automatic logic [TW-1:0] cnt_dec(input logic [TW-1:0] c);
    return (c == '0) ? c : c - ONE;
  endfunction

  function automatic logic [TW-1:0] cnt_inc(input logic [TW-1:0] c);
    return (c == CNT_MAX) ? c : c + ONE;
  endfunction

  logic hazard;
  assign hazard = load_use(id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_memread);

  always_comb begin
    nxt           = cur;
    cnt_nxt       = cnt;
    tmo_nxt       = 1'b0;
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    idex_stall_c  = 1'b0;
    idex_bubble_c = 1'b0;
    exmem_stall_c = 1'b0;
    flush_c       = 1'b0;
    io_req_c      = 1'b0;
    case (cur)
      RUN, LOAD_STALL: begin
        // A taken branch wins over everything, including an in-progress load stall.
        if (mem_branch_taken) begin
          flush_c = 1'b1;
          nxt     = RUN;
          if (FLUSH_CYCLES > 1) begin
            nxt     = BR_FLUSH;
            cnt_nxt = FLUSH_LOAD;
          end
        end else if (cur == LOAD_STALL) begin
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          idex_bubble_c = 1'b1;
          cnt_nxt       = cnt_dec(cnt);
          if (cnt <= ONE) nxt = RUN;
        end else if (mem_io_access) begin
          io_req_c = 1'b1;
          // An ack in the entry cycle completes the access without freezing anything.
          if (!io_ack) begin
            pc_stall_c    = 1'b1;
            ifid_stall_c  = 1'b1;
            idex_stall_c  = 1'b1;
            exmem_stall_c = 1'b1;
            nxt           = IO_WAIT;
            cnt_nxt       = ONE;
          end
        end else if (hazard) begin
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          idex_bubble_c = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            nxt     = LOAD_STALL;
            cnt_nxt = STALL_LOAD;
          end
        end
      end
      BR_FLUSH: begin
        flush_c = 1'b1;
        cnt_nxt = cnt_dec(cnt);
        if (cnt <= ONE) nxt = RUN;
      end
      IO_WAIT: begin
        if (io_ack) begin
          nxt = RUN;
        end else if (cnt >= TMO_LIMIT) begin
          nxt     = RUN;
          tmo_nxt = 1'b1;
        end else begin
          io_req_c      = 1'b1;
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          idex_stall_c  = 1'b1;
          exmem_stall_c = 1'b1;
          cnt_nxt       = cnt_inc(cnt);
        end
      end
      default: nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= RUN;
      cnt   <= '0;
      tmo_q <= 1'b0;
    end else begin
      cur   <= nxt;
      cnt   <= cnt_nxt;
      tmo_q <= tmo_nxt;
    end
  end

  // Outputs are forced low for the whole time reset is held, independent of inputs.
  assign pc_stall    = rst_n & pc_stall_c;
  assign ifid_stall  = rst_n & ifid_stall_c;
  assign idex_stall  = rst_n & idex_stall_c;
  assign idex_bubble = rst_n & idex_bubble_c;
  assign exmem_stall = rst_n & exmem_stall_c;
  assign flush       = rst_n & flush_c;
  assign io_req      = rst_n & io_req_c;
  assign io_timeout  = rst_n & tmo_q;
  assign state       = rst_n ? cur : 2'd0;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(flush_c && (pc_stall_c || ifid_stall_c || idex_stall_c || exmem_stall_c)));
      assert (!(idex_bubble_c && idex_stall_c));
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed per-cycle vectors with hand-computed
// expected outputs queued by the driver and checked by an independent monitor.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs2 = 1'b0, ex_memread = 1'b0;
  logic       mem_branch_taken = 1'b0, mem_io_access = 1'b0, io_ack = 1'b0;
  logic       pc_stall, ifid_stall, idex_stall, idex_bubble, exmem_stall;
  logic       flush, io_req, io_timeout;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0] exp;
    string      name;
  } exp_t;
  exp_t sb[$];

  // {pc, ifid, idex, bubble, exmem, flush, io_req, io_timeout}
  localparam logic [7:0] Z   = 8'b0000_0000;
  localparam logic [7:0] LU  = 8'b1101_0000;
  localparam logic [7:0] FL  = 8'b0000_0100;
  localparam logic [7:0] IOS = 8'b1110_1010;
  localparam logic [7:0] REQ = 8'b0000_0010;
  localparam logic [7:0] TMO = 8'b0000_0001;
  localparam logic [1:0] S_RUN = 2'd0, S_BR = 2'd2, S_IO = 2'd3;

  pipe_hazard_ctrl #(
    .LOAD_STALL_CYCLES(1),
    .FLUSH_CYCLES(3),
    .IO_TIMEOUT(10),
    .TW(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_branch_taken(mem_branch_taken), .mem_io_access(mem_io_access), .io_ack(io_ack),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .idex_bubble(idex_bubble), .exmem_stall(exmem_stall), .flush(flush),
    .io_req(io_req), .io_timeout(io_timeout), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rn, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u2, input logic [4:0] rd, input logic mr,
                      input logic br, input logic io, input logic ack,
                      input logic [7:0] f, input logic [1:0] st, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n            = rn;
    id_rs1           = rs1;
    id_rs2           = rs2;
    id_uses_rs2      = u2;
    ex_rd            = rd;
    ex_memread       = mr;
    mem_branch_taken = br;
    mem_io_access    = io;
    io_ack           = ack;
    e.exp  = {f, st};
    e.name = nm;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {pc_stall, ifid_stall, idex_stall, idex_bubble, exmem_stall,
               flush, io_req, io_timeout, state};
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %b required %b", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin : stimulus
    //   rn rs1 rs2 u2 rd  mr br io ack
    step(0, 5, 0, 0, 5, 1, 1, 0, 0, Z,   S_RUN, "rst_outputs");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z,   S_RUN, "idle");
    step(1, 5, 0, 0, 5, 1, 0, 0, 0, LU,  S_RUN, "lu_rs1");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z,   S_RUN, "lu_release");
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, Z,   S_RUN, "rd_zero");
    step(1, 3, 7, 0, 7, 1, 0, 0, 0, Z,   S_RUN, "rs2_gated");
    step(1, 3, 7, 1, 7, 1, 0, 0, 0, LU,  S_RUN, "rs2_used");
    step(1, 5, 0, 0, 5, 0, 0, 0, 0, Z,   S_RUN, "no_load");
    step(1, 5, 0, 0, 5, 1, 1, 0, 0, FL,  S_RUN, "br_hazard");
    step(1, 5, 0, 0, 5, 1, 0, 1, 0, FL,  S_BR,  "br_hold1");
    step(1, 5, 0, 0, 5, 1, 0, 1, 0, FL,  S_BR,  "br_hold2");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z,   S_RUN, "br_done");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, IOS, S_RUN, "io_enter");
    step(1, 5, 0, 0, 5, 1, 1, 1, 0, IOS, S_IO,  "io_wait1");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, IOS, S_IO,  "io_wait2");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, IOS, S_IO,  "io_wait3");
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, Z,   S_IO,  "io_ack");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z,   S_RUN, "io_done");
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, REQ, S_RUN, "io_ack_fast");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z,   S_RUN, "fast_done");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, IOS, S_RUN, "tmo_enter");
    for (int i = 1; i <= 9; i++)
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, IOS, S_IO, $sformatf("tmo_wait%0d", i));
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, Z,   S_IO,  "tmo_release");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, TMO, S_RUN, "tmo_pulse");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z,   S_RUN, "tmo_pulse_end");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, IOS, S_RUN, "rio_enter");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, IOS, S_IO,  "rio_wait");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, Z,   S_RUN, "rst_mid_io");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z,   S_RUN, "rst_release");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, IOS, S_RUN, "post_rst_io");
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, Z,   S_IO,  "post_rst_ack");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, Z,   S_RUN, "post_rst_done");
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries required 0", sb.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
